// File: rtl/decoder_seq_pkg.sv
// Shared types and helpers for the timed one-hot line decoder.
package decoder_seq_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // A hold request of 0 is stretched to this many cycles.
    localparam int unsigned HOLD_MIN   = 1;

    // Widest decode the helper can produce; callers slice down to their width.
    localparam int unsigned ONEHOT_MAX = 256;

    // One-hot of sel, or all-zero when sel does not name an existing line.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [31:0] sel,
                                                     input int unsigned num_out);
        logic [ONEHOT_MAX-1:0] r;
        r = '0;
        if ((sel < num_out) && (sel < ONEHOT_MAX)) begin
            r[sel[7:0]] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_hold_timer.sv
// Hold-time down-counter: loads a request length (0 clamped to 1) and
// counts it down; last_o marks the final cycle of the hold.
module decoder_hold_timer
    import decoder_seq_pkg::*;
#(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [HOLD_W-1:0] load_val_i,
    output logic [HOLD_W-1:0] cnt_o,
    output logic              last_o
);

    logic [HOLD_W-1:0] cnt_q, cnt_d;

    // Next count: a load wins over the decrement; the count parks at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (load_val_i == '0) ? HOLD_W'(HOLD_MIN) : load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == HOLD_W'(1));

endmodule

// File: rtl/decoder_seq_nto2n.sv
// Registered binary-to-one-hot line driver with valid/ready intake and a
// per-request hold time. Back-to-back requests hand over on the last cycle
// with no idle gap. Selects beyond NUM_OUT are timed but drive no line and
// raise err for one cycle.
// Build option: DECODER_ACTIVE_LOW_EN drives d one-cold (idle = all ones).
module decoder_seq_nto2n
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int HOLD_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic [HOLD_W-1:0]  hold,
    output logic [NUM_OUT-1:0] d,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned NOUT = NUM_OUT;

    state_e               state_q, state_d;
    logic [NUM_OUT-1:0]   d_q, d_d;
    logic                 err_q, err_d;
    logic                 accept;
    logic                 last;
    logic                 sel_bad;
    logic [ONEHOT_MAX-1:0] oh_full;
    logic [HOLD_W-1:0]    cnt_unused;

    assign oh_full = onehot(32'(sel), NOUT);
    assign sel_bad = (32'(sel) >= NOUT);
    assign accept  = in_valid && in_ready;

    // Upper decode bits can never be set for a legal line index.
    if (NUM_OUT < ONEHOT_MAX) begin : g_oh_tail
        logic unused_oh_tail;
        assign unused_oh_tail = ^oh_full[ONEHOT_MAX-1:NUM_OUT];
    end

    decoder_hold_timer #(
        .HOLD_W (HOLD_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (hold),
        .cnt_o      (cnt_unused),
        .last_o     (last)
    );

    // Next state and ready: open for a request in IDLE and on the last held cycle.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (last) begin
                    in_ready = 1'b1;
                    if (!in_valid) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line register: a new accept replaces the line outright, so the
    // handover is never multi-hot; otherwise clear after the last cycle.
    always_comb begin
        d_d   = d_q;
        err_d = accept && sel_bad;
        if (accept) begin
            d_d = oh_full[NUM_OUT-1:0];
        end else if ((state_q == ACTIVE) && last) begin
            d_d = '0;
        end
    end

    // State, line and error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            d_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == ACTIVE);
    assign done = (state_q == ACTIVE) && last;
    assign err  = err_q;

`ifdef DECODER_ACTIVE_LOW_EN
    assign d = ~d_q;
`else
    assign d = d_q;
`endif

endmodule

// File: tb/tb_decoder_seq_nto2n.sv
// Directed bench for decoder_seq_nto2n: a full 8-line instance plus a
// 6-line instance for out-of-range selects. Expected d is written in
// active-high form and inverted when the active-low build is selected.
module tb_decoder_seq_nto2n;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       v8, rdy8, busy8, done8, err8;
    logic [2:0] sel8;
    logic [3:0] hold8;
    logic [7:0] d8;
    logic       v6, rdy6, busy6, done6, err6;
    logic [2:0] sel6;
    logic [3:0] hold6;
    logic [5:0] d6;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decoder_seq_nto2n #(.SEL_W(3), .NUM_OUT(8), .HOLD_W(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
        .sel(sel8), .hold(hold8), .d(d8), .busy(busy8), .done(done8), .err(err8));

    decoder_seq_nto2n #(.SEL_W(3), .NUM_OUT(6), .HOLD_W(4)) dut6 (
        .clk(clk), .reset(reset), .in_valid(v6), .in_ready(rdy6),
        .sel(sel6), .hold(hold6), .d(d6), .busy(busy6), .done(done6), .err(err6));

    function automatic logic [7:0] e8(input logic [7:0] x);
        return AL ? ~x : x;
    endfunction

    function automatic logic [5:0] e6(input logic [5:0] x);
        return AL ? ~x : x;
    endfunction

    // Observation layout: {d, busy, done, err, in_ready}
    task automatic test_reset();
        logic [11:0] obs, exp;
        reset = 1'b1; v8 = 1'b0; sel8 = '0; hold8 = '0;
        v6 = 1'b0; sel6 = '0; hold6 = '0;
        repeat (3) @(negedge clk);
        obs = {d8, busy8, done8, err8, rdy8};
        exp = {e8(8'h00), 4'b0001};
        n_tests++;
        if (obs !== exp) begin
            $display("FAIL reset8: got %h expected %h", obs, exp); n_fail++;
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({d6, busy6, done6, err6, rdy6} !== {e6(6'h00), 4'b0001}) begin
            $display("FAIL reset6: got %h expected %h",
                     {d6, busy6, done6, err6, rdy6}, {e6(6'h00), 4'b0001}); n_fail++;
        end
    endtask

    task automatic test_basic();
        logic [7:0] ed [4] = '{8'h20, 8'h20, 8'h20, 8'h00};
        logic [3:0] ef [4] = '{4'b1000, 4'b1000, 4'b1101, 4'b0001};
        logic [11:0] obs, exp;
        @(negedge clk); v8 = 1'b1; sel8 = 3'd5; hold8 = 4'd3;
        @(negedge clk); v8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            obs = {d8, busy8, done8, err8, rdy8};
            exp = {e8(ed[i]), ef[i]};
            n_tests++;
            if (obs !== exp) begin
                $display("FAIL basic_s5h3 cyc%0d: got %h expected %h", i, obs, exp); n_fail++;
            end
        end
    endtask

    task automatic test_hold0();
        logic [7:0] ed [2] = '{8'h04, 8'h00};
        logic [3:0] ef [2] = '{4'b1101, 4'b0001};
        logic [11:0] obs, exp;
        @(negedge clk); v8 = 1'b1; sel8 = 3'd2; hold8 = 4'd0;
        @(negedge clk); v8 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            obs = {d8, busy8, done8, err8, rdy8};
            exp = {e8(ed[i]), ef[i]};
            n_tests++;
            if (obs !== exp) begin
                $display("FAIL hold0 cyc%0d: got %h expected %h", i, obs, exp); n_fail++;
            end
        end
    endtask

    task automatic test_sel0();
        logic [7:0] ed [2] = '{8'h01, 8'h00};
        logic [3:0] ef [2] = '{4'b1101, 4'b0001};
        logic [11:0] obs, exp;
        @(negedge clk); v8 = 1'b1; sel8 = 3'd0; hold8 = 4'd1;
        @(negedge clk); v8 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            obs = {d8, busy8, done8, err8, rdy8};
            exp = {e8(ed[i]), ef[i]};
            n_tests++;
            if (obs !== exp) begin
                $display("FAIL sel0_h1 cyc%0d: got %h expected %h", i, obs, exp); n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ed [5] = '{8'h02, 8'h02, 8'h80, 8'h80, 8'h00};
        logic [3:0] ef [5] = '{4'b1000, 4'b1101, 4'b1000, 4'b1101, 4'b0001};
        logic [11:0] obs, exp;
        logic [7:0] act;
        @(negedge clk); v8 = 1'b1; sel8 = 3'd1; hold8 = 4'd2;
        @(negedge clk); sel8 = 3'd7; hold8 = 4'd2;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            obs = {d8, busy8, done8, err8, rdy8};
            exp = {e8(ed[i]), ef[i]};
            n_tests++;
            if (obs !== exp) begin
                $display("FAIL b2b cyc%0d: got %h expected %h", i, obs, exp); n_fail++;
            end
            act = AL ? ~d8 : d8;
            n_tests++;
            if ($countones(act) > 1) begin
                $display("FAIL b2b_multihot cyc%0d: got %h expected at most one line", i, act);
                n_fail++;
            end
            if (i == 2) v8 = 1'b0;
        end
    endtask

    task automatic test_invalid_sel();
        logic [3:0] ef [3] = '{4'b1010, 4'b1101, 4'b0001};
        logic [9:0] obs, exp;
        @(negedge clk); v6 = 1'b1; sel6 = 3'd6; hold6 = 4'd2;
        @(negedge clk); v6 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            obs = {d6, busy6, done6, err6, rdy6};
            exp = {e6(6'h00), ef[i]};
            n_tests++;
            if (obs !== exp) begin
                $display("FAIL badsel6 cyc%0d: got %h expected %h", i, obs, exp); n_fail++;
            end
        end
    endtask

    task automatic test_max_hold();
        int on_cyc = 0, done_cyc = 0;
        @(negedge clk); v8 = 1'b1; sel8 = 3'd3; hold8 = 4'd15;
        @(negedge clk); v8 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (d8 === e8(8'h08)) on_cyc++;
            if (done8 === 1'b1) done_cyc++;
            if (busy8 !== 1'b1) break;
            @(negedge clk);
        end
        n_tests++;
        if (on_cyc != 15 || done_cyc != 1) begin
            $display("FAIL max_hold: got %0d on / %0d done, expected 15 on / 1 done",
                     on_cyc, done_cyc); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] obs, exp;
        @(negedge clk); v8 = 1'b1; sel8 = 3'd3; hold8 = 4'd10;
        @(negedge clk); v8 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (d8 !== e8(8'h08)) begin
            $display("FAIL rstmid_pre: got %h expected %h", d8, e8(8'h08)); n_fail++;
        end
        reset = 1'b1; v8 = 1'b1; sel8 = 3'd4; hold8 = 4'd1;
        @(negedge clk);
        obs = {d8, busy8, done8, err8, 1'b0};
        exp = {e8(8'h00), 4'b0000};
        n_tests++;
        if (obs !== exp) begin
            $display("FAIL rstmid_in_reset: got %h expected %h", obs, exp); n_fail++;
        end
        reset = 1'b0; v8 = 1'b0;
        @(negedge clk);
        obs = {d8, busy8, done8, err8, rdy8};
        exp = {e8(8'h00), 4'b0001};
        n_tests++;
        if (obs !== exp) begin
            $display("FAIL rstmid_after: got %h expected %h", obs, exp); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold0();
        test_sel0();
        test_back_to_back();
        test_invalid_sel();
        test_max_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
